// File: rtl/cache_mem_backend.sv
// cache_mem_backend: line-granularity memory behind the L1 controller; serves one refill read or
// write-back at a time after a fixed latency, with writes winning arbitration over reads.
module cache_mem_backend #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH_M = 128,
  parameter int DEPTH        = 256,
  parameter int LATENCY      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      r_req_valid,
  output logic                      r_req_ready,
  input  logic [ADDR_WIDTH-1:0]     r_req_addr,
  output logic                      r_resp_valid,
  input  logic                      r_resp_ready,
  output logic [DATA_WIDTH_M-1:0]   r_resp_rdata,
  output logic [1:0]                r_resp_rresp,
  input  logic                      w_req_valid,
  output logic                      w_req_ready,
  input  logic [ADDR_WIDTH-1:0]     w_req_addr,
  input  logic [DATA_WIDTH_M-1:0]   w_req_data,
  input  logic [DATA_WIDTH_M/8-1:0] w_req_wmask,
  output logic                      w_resp_valid,
  input  logic                      w_resp_ready,
  output logic [1:0]                w_resp_bresp
);
  localparam int IW = $clog2(DEPTH);
  localparam int BW = DATA_WIDTH_M / 8;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, R_WAIT, W_WAIT, R_RESP, W_RESP} state_t;
  state_t                  r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH_M-1:0] r_data, r_rdata;
  logic [BW-1:0]           r_wmask;
  logic [1:0]              r_rresp, r_bresp;
  logic [DATA_WIDTH_M-1:0] r_mem [DEPTH];
  logic [IW-1:0]           w_idx;
  logic                    w_oor, w_acc_w, w_acc_r, w_done;
  // readies are forced low while reset is held so nothing looks acceptable mid-reset
  assign w_req_ready  = (r_state == IDLE) && !rst;
  assign r_req_ready  = w_req_ready && !w_req_valid;
  assign w_acc_w      = w_req_ready && w_req_valid;
  assign w_acc_r      = r_req_ready && r_req_valid;
  assign w_done       = r_cnt == '0;
  assign w_idx        = r_addr[4 +: IW];
  assign w_oor        = (r_addr >> (4 + IW)) != '0;
  assign r_resp_valid = r_state == R_RESP;
  assign w_resp_valid = r_state == W_RESP;
  assign r_resp_rdata = r_rdata;
  assign r_resp_rresp = r_rresp;
  assign w_resp_bresp = r_bresp;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_req_valid ? W_WAIT : r_req_valid ? R_WAIT : IDLE;
      R_WAIT:  w_next = w_done ? R_RESP : R_WAIT;
      W_WAIT:  w_next = w_done ? W_RESP : W_WAIT;
      R_RESP:  w_next = r_resp_ready ? IDLE : R_RESP;
      W_RESP:  w_next = w_resp_ready ? IDLE : W_RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
      r_bresp <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_w || w_acc_r) begin
        r_addr <= w_acc_w ? w_req_addr : r_req_addr;
        r_cnt  <= CW'(LATENCY - 1);
      end else if ((r_state == R_WAIT || r_state == W_WAIT) && !w_done) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_acc_w) begin
        r_data  <= w_req_data;
        r_wmask <= w_req_wmask;
      end
      if (r_state == R_WAIT && w_done) begin
        r_rdata <= w_oor ? '0 : r_mem[w_idx];
        r_rresp <= w_oor ? 2'b10 : 2'b00;
      end
      if (r_state == W_WAIT && w_done) r_bresp <= w_oor ? 2'b10 : 2'b00;
    end
  end
  // the line array is deliberately never reset
  always_ff @(posedge clk) begin
    if (r_state == W_WAIT && w_done && !w_oor)
      for (int b = 0; b < BW; b++)
        if (r_wmask[b]) r_mem[w_idx][8*b +: 8] <= r_data[8*b +: 8];
  end
endmodule

// File: tb/tb_cache_mem_backend.sv
// tb_cache_mem_backend: directed stimulus with queued expectations, checked by a response monitor.
module tb_cache_mem_backend;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         r_req_valid, r_req_ready, r_resp_valid, r_resp_ready;
  logic [31:0]  r_req_addr, w_req_addr;
  logic [127:0] r_resp_rdata, w_req_data;
  logic [1:0]   r_resp_rresp, w_resp_bresp;
  logic         w_req_valid, w_req_ready, w_resp_valid, w_resp_ready;
  logic [15:0]  w_req_wmask;
  int           n_chk = 0;
  int           n_fail = 0;
  logic [129:0] rq[$];
  logic [1:0]   wq[$];

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] P0 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [127:0] Q  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] R  = 128'h99990000_99990000_99990000_99990000;
  localparam logic [127:0] S  = 128'h0F0F0F0F_F0F0F0F0_0F0F0F0F_F0F0F0F0;

  cache_mem_backend dut (
    .clk(clk), .rst(rst),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_req_addr(r_req_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready),
    .r_resp_rdata(r_resp_rdata), .r_resp_rresp(r_resp_rresp),
    .w_req_valid(w_req_valid), .w_req_ready(w_req_ready), .w_req_addr(w_req_addr),
    .w_req_data(w_req_data), .w_req_wmask(w_req_wmask),
    .w_resp_valid(w_resp_valid), .w_resp_ready(w_resp_ready), .w_resp_bresp(w_resp_bresp)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    logic [129:0] e;
    if (r_resp_valid && r_resp_ready) begin
      if (rq.size() == 0) chk("r_resp_unexpected", 1, 0);
      else begin
        e = rq.pop_front();
        chk("rdata", r_resp_rdata, e[127:0]);
        chk("rresp", 128'(r_resp_rresp), 128'(e[129:128]));
      end
    end
    if (w_resp_valid && w_resp_ready) begin
      if (wq.size() == 0) chk("w_resp_unexpected", 1, 0);
      else chk("bresp", 128'(w_resp_bresp), 128'(wq.pop_front()));
    end
  end

  task automatic wait_lat(input bit is_w, input string name);
    int lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(is_w ? w_resp_valid : r_resp_valid) && lat < 20);
    chk(name, lat, 4);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!w_req_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("back_to_idle", 128'(w_req_ready), 1);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m);
    int k = 0;
    @(negedge clk);
    w_req_valid = 1; w_req_addr = a; w_req_data = d; w_req_wmask = m;
    while (!w_req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    w_req_valid = 0;
  endtask

  task automatic send_r(input logic [31:0] a);
    int k = 0;
    @(negedge clk);
    r_req_valid = 1; r_req_addr = a;
    while (!r_req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    r_req_valid = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [127:0] d, input logic [15:0] m,
                          input logic [1:0] br);
    send_w(a, d, m);
    wq.push_back(br);
    wait_lat(1, "w_latency");
    wait_idle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [127:0] d, input logic [1:0] rr);
    send_r(a);
    rq.push_back({rr, d});
    wait_lat(0, "r_latency");
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    r_req_valid = 0; r_req_addr = '0; w_req_valid = 0; w_req_addr = '0;
    w_req_data = '0; w_req_wmask = '0; r_resp_ready = 1; w_resp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_w_req_ready", 128'(w_req_ready), 0);
    chk("rst_r_req_ready", 128'(r_req_ready), 0);
    chk("rst_r_resp_valid", 128'(r_resp_valid), 0);
    chk("rst_w_resp_valid", 128'(w_resp_valid), 0);
    chk("rst_rdata", r_resp_rdata, 0);
    chk("rst_resps", 128'({r_resp_rresp, w_resp_bresp}), 0);
    @(negedge clk) rst = 0;
    #1 chk("idle_w_req_ready", 128'(w_req_ready), 1);
    // full-line write then read back
    do_write(32'h10, D1, 16'hFFFF, 2'b00);
    do_read(32'h10, D1, 2'b00);
    // partial write and empty mask
    do_write(32'h20, {16{8'hAA}}, 16'hFFFF, 2'b00);
    do_write(32'h20, {16{8'h55}}, 16'h000F, 2'b00);
    do_read(32'h20, 128'hAAAAAAAAAAAAAAAAAAAAAAAA55555555, 2'b00);
    do_write(32'h20, '0, 16'h0000, 2'b00);
    do_read(32'h20, 128'hAAAAAAAAAAAAAAAAAAAAAAAA55555555, 2'b00);
    // simultaneous write and read to the same line
    @(negedge clk);
    w_req_valid = 1; w_req_addr = 32'h40; w_req_data = S; w_req_wmask = 16'hFFFF;
    r_req_valid = 1; r_req_addr = 32'h40;
    #1;
    chk("arb_r_req_ready", 128'(r_req_ready), 0);
    chk("arb_w_req_ready", 128'(w_req_ready), 1);
    @(posedge clk); #1;
    w_req_valid = 0;
    wq.push_back(2'b00);
    rq.push_back({2'b00, S});
    n = 0;
    while (!r_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    r_req_valid = 0;
    n++;
    chk("arb_read_accept_edge", n, 6);
    wait_lat(0, "arb_r_latency");
    wait_idle();
    // response backpressure
    r_resp_ready = 0;
    send_r(32'h10);
    rq.push_back({2'b00, D1});
    wait_lat(0, "bp_latency");
    w_req_valid = 1; w_req_addr = 32'h10; w_req_data = '0; w_req_wmask = 16'hFFFF;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid_held", 128'(r_resp_valid), 1);
      chk("bp_rdata_stable", r_resp_rdata, D1);
      chk("bp_no_accept", 128'(w_req_ready), 0);
    end
    @(posedge clk); #1;
    r_resp_ready = 1;
    w_req_valid = 0;
    @(posedge clk); #1;
    chk("bp_valid_drop", 128'(r_resp_valid), 0);
    wait_idle();
    do_read(32'h10, D1, 2'b00);
    // out-of-range accesses
    do_write(32'h0, P0, 16'hFFFF, 2'b00);
    do_read(32'h1000, '0, 2'b10);
    do_write(32'h1000, '1, 16'hFFFF, 2'b10);
    do_read(32'h0, P0, 2'b00);
    // reset while a write is waiting
    do_write(32'h30, Q, 16'hFFFF, 2'b00);
    do_read(32'h10, D1, 2'b00);
    send_w(32'h30, R, 16'hFFFF);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("mid_rst_w_resp_valid", 128'(w_resp_valid), 0);
    chk("mid_rst_readies", 128'({w_req_ready, r_req_ready}), 0);
    chk("mid_rst_r_resp_valid", 128'(r_resp_valid), 0);
    chk("mid_rst_rdata", r_resp_rdata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 0;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_w_resp", 128'(w_resp_valid), 0);
    end
    do_read(32'h30, Q, 2'b00);
    repeat (5) @(posedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
